folding_2_feeder: RTL and testbench

//  Upstream stage of folding_2: turns a valid/ready sample stream into the folded schedule that folding_2 needs.

---
 rtl/folding2_pkg.sv | 23 ++
 rtl/fold_fifo.sv | 65 ++++++
 rtl/folding_2_feeder.sv | 150 +++++++++++++++
 tb/tb_folding_2_feeder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/folding2_pkg.sv
// Shared constants and types for the folding_2 feeder and its FIFO.
package folding2_pkg;

    localparam int N_DEF     = 16;
    localparam int DEPTH_DEF = 4;
    localparam int FOLD      = 2;
    localparam int A_RST_DEF = 2;
    localparam int B_RST_DEF = 3;
    localparam int UCNT_W    = 8;

    // Fold phase: PH_FIRST drives switch=1, PH_SECOND drives switch=0.
    // The edge leaving PH_SECOND is the fold boundary.
    typedef enum logic {
        PH_SECOND = 1'b0,
        PH_FIRST  = 1'b1
    } phase_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [UCNT_W-1:0] sat_inc(input logic [UCNT_W-1:0] v);
        return (v == {UCNT_W{1'b1}}) ? v : v + UCNT_W'(1);
    endfunction

endpackage

// File: rtl/fold_fifo.sv
// Small synchronous FIFO with extra-MSB pointers; full/empty come from
// comparing pointer MSBs, the read port is a direct look at the head entry.
module fold_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int PW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [PW-1:0] count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next-state: write at the tail, advance pointers independently so a
    // simultaneous push and pop leaves the count unchanged.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Storage and pointer registers; reset discards anything queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/folding_2_feeder.sv
// Feeder for folding_2: buffers a valid/ready sample stream and replays it
// one sample per 2-clock fold period, with phase, coefficient shadowing and
// underrun accounting.
module folding_2_feeder
    import folding2_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int A_RST = A_RST_DEF,
    parameter int B_RST = B_RST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [N-1:0]      a_in,
    input  logic [N-1:0]      b_in,
    input  logic              coef_load,
    output logic [N-1:0]      Xn,
    output logic              x_valid,
    output logic              switch,
    output logic [N-1:0]      a,
    output logic [N-1:0]      b,
    output logic [UCNT_W-1:0] underrun_cnt
);

    localparam int PW = $clog2(DEPTH) + 1;

    logic [N-1:0]      fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PW-1:0]     fifo_count;
    logic              fifo_unused;
    logic              push;
    logic              pop;
    logic              boundary;

    phase_e            phase_q, phase_d;
    logic [N-1:0]      xn_q, xn_d;
    logic              x_valid_q, x_valid_d;
    logic [N-1:0]      a_q, a_d;
    logic [N-1:0]      b_q, b_d;
    logic [N-1:0]      a_sh_q, a_sh_d;
    logic [N-1:0]      b_sh_q, b_sh_d;
    logic              pend_q, pend_d;
    logic              run_q, run_d;
    logic [UCNT_W-1:0] ucnt_q, ucnt_d;

    // Backpressure comes from the registered count; full is implied by it.
    assign s_ready     = !rst && (fifo_count < PW'(DEPTH));
    assign fifo_unused = fifo_full;
    assign push        = s_valid && s_ready;
    // The edge that leaves the switch=0 half-period starts a new fold period.
    assign boundary    = (phase_q == PH_SECOND);
    // Pop decision looks at the FIFO before the edge, so a sample pushed on a
    // boundary edge is never consumed on that same edge.
    assign pop         = boundary && !fifo_empty;

    fold_fifo #(
        .W     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (s_data),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Next-state for phase, sample output, coefficients and underrun count.
    always_comb begin
        phase_d   = (phase_q == PH_FIRST) ? PH_SECOND : PH_FIRST;
        xn_d      = xn_q;
        x_valid_d = x_valid_q;
        a_d       = a_q;
        b_d       = b_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        pend_d    = pend_q;
        ucnt_d    = ucnt_q;
        run_d     = run_q || push;

        if (boundary) begin
            if (!fifo_empty) begin
                xn_d      = fifo_head;
                x_valid_d = 1'b1;
            end else begin
                xn_d      = '0;
                x_valid_d = 1'b0;
                // Bubbles before the first ever sample are start-up, not underrun.
                if (run_q) begin
                    ucnt_d = sat_inc(ucnt_q);
                end
            end
            if (pend_q) begin
                a_d    = a_sh_q;
                b_d    = b_sh_q;
                pend_d = 1'b0;
            end
        end

        // A load always re-arms pend, so a load on a boundary edge waits for
        // the following boundary and the newest load overrides older ones.
        if (coef_load) begin
            a_sh_d = a_in;
            b_sh_d = b_in;
            pend_d = 1'b1;
        end
    end

    // State registers; reset forces outputs immediately, independent of clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q   <= PH_FIRST;
            xn_q      <= '0;
            x_valid_q <= 1'b0;
            a_q       <= N'(A_RST);
            b_q       <= N'(B_RST);
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            pend_q    <= 1'b0;
            run_q     <= 1'b0;
            ucnt_q    <= '0;
        end else begin
            phase_q   <= phase_d;
            xn_q      <= xn_d;
            x_valid_q <= x_valid_d;
            a_q       <= a_d;
            b_q       <= b_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            pend_q    <= pend_d;
            run_q     <= run_d;
            ucnt_q    <= ucnt_d;
        end
    end

    assign Xn           = xn_q;
    assign x_valid      = x_valid_q;
    assign switch       = (phase_q == PH_FIRST);
    assign a            = a_q;
    assign b            = b_q;
    assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_folding_2_feeder.sv
// Directed bench for folding_2_feeder: reset, streaming, burst/backpressure,
// underrun saturation, coefficient shadowing and mid-run reset.
module tb_folding_2_feeder;

    logic        clk;
    logic        rst;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        coef_load;
    logic [15:0] Xn;
    logic        x_valid;
    logic        switch;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  underrun_cnt;

    int total;
    int bad;

    logic [15:0] stream_v [6] = '{16'hFFFD, 16'h0005, 16'h0002, 16'hFFFE, 16'h0004, 16'h0001};
    logic [9:0]  exp_rdy = 10'b0101111111;

    folding_2_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .a_in         (a_in),
        .b_in         (b_in),
        .coef_load    (coef_load),
        .Xn           (Xn),
        .x_valid      (x_valid),
        .switch       (switch),
        .a            (a),
        .b            (b),
        .underrun_cnt (underrun_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance (bounded) to a negedge where switch equals want.
    task automatic goto_phase(input logic want);
        int n;
        n = 0;
        while (switch !== want && n < 4) begin
            @(negedge clk);
            n++;
        end
        if (switch !== want) begin
            total++;
            bad++;
            $display("FAIL goto_phase: switch=%b required %b", switch, want);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        s_valid   = 1'b0;
        coef_load = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
        total++; if (switch !== 1'b1) begin bad++; $display("FAIL reset_switch: got %b want 1", switch); end
        total++; if (Xn !== 16'h0000) begin bad++; $display("FAIL reset_xn: got %h want 0000", Xn); end
        total++; if (x_valid !== 1'b0) begin bad++; $display("FAIL reset_x_valid: got %b want 0", x_valid); end
        total++; if (a !== 16'd2) begin bad++; $display("FAIL reset_a: got %0d want 2", a); end
        total++; if (b !== 16'd3) begin bad++; $display("FAIL reset_b: got %0d want 3", b); end
        total++; if (underrun_cnt !== 8'd0) begin bad++; $display("FAIL reset_ucnt: got %0d want 0", underrun_cnt); end
        rst = 1'b0;
        #1;
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL release_s_ready: got %b want 1", s_ready); end
        @(negedge clk);
        total++; if (switch !== 1'b0) begin bad++; $display("FAIL edge1_switch: got %b want 0", switch); end
        @(negedge clk);
        total++; if (switch !== 1'b1) begin bad++; $display("FAIL edge2_switch: got %b want 1", switch); end
        total++; if (x_valid !== 1'b0) begin bad++; $display("FAIL edge2_x_valid: got %b want 0", x_valid); end
        $display("reset: released, switch toggled 1->0->1");
    endtask

    task automatic test_stream();
        for (int i = 0; i < 6; i++) begin
            goto_phase(1'b0);
            s_valid = 1'b1;
            s_data  = stream_v[i];
            total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d]: got %b want 1", i, s_ready); end
            @(negedge clk);
            s_valid = 1'b0;
            if (i == 0) begin
                total++; if (x_valid !== 1'b0 || Xn !== 16'h0000) begin bad++; $display("FAIL stream_first_bubble: got xv=%b xn=%h want 0/0000", x_valid, Xn); end
            end else begin
                total++; if (Xn !== stream_v[i-1] || x_valid !== 1'b1 || switch !== 1'b1) begin
                    bad++; $display("FAIL stream_xn_p1[%0d]: got xn=%h xv=%b sw=%b want %h/1/1", i-1, Xn, x_valid, switch, stream_v[i-1]);
                end
            end
            @(negedge clk);
            if (i > 0) begin
                total++; if (Xn !== stream_v[i-1] || switch !== 1'b0) begin
                    bad++; $display("FAIL stream_xn_p2[%0d]: got xn=%h sw=%b want %h/0", i-1, Xn, switch, stream_v[i-1]);
                end
            end
            $display("stream: pushed %h", stream_v[i]);
        end
        @(negedge clk);
        total++; if (Xn !== stream_v[5] || x_valid !== 1'b1) begin bad++; $display("FAIL stream_last: got xn=%h xv=%b want %h/1", Xn, x_valid, stream_v[5]); end
        @(negedge clk);
        total++; if (Xn !== stream_v[5]) begin bad++; $display("FAIL stream_last_hold: got %h want %h", Xn, stream_v[5]); end
        total++; if (underrun_cnt !== 8'd0) begin bad++; $display("FAIL stream_no_early_count: got %0d want 0", underrun_cnt); end
    endtask

    task automatic test_burst();
        logic [15:0] got [8];
        int          k;
        int          n;
        logic        acc;
        goto_phase(1'b1);
        k = 0;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (k < 8) begin
                s_valid = 1'b1;
                s_data  = 16'h8010 + 16'(k);
            end else begin
                s_valid = 1'b0;
            end
            acc = s_valid && s_ready;
            if (c < 10) begin
                total++; if (s_ready !== exp_rdy[c]) begin bad++; $display("FAIL burst_ready[%0d]: got %b want %b", c, s_ready, exp_rdy[c]); end
            end
            @(negedge clk);
            if (acc) k++;
            if (switch === 1'b1 && x_valid === 1'b1) begin
                if (n < 8) got[n] = Xn;
                n++;
            end
        end
        s_valid = 1'b0;
        total++; if (n != 8) begin bad++; $display("FAIL burst_count: got %0d samples want 8", n); end
        for (int i = 0; i < 8; i++) begin
            total++; if (got[i] !== 16'h8010 + 16'(i)) begin bad++; $display("FAIL burst_order[%0d]: got %h want %h", i, got[i], 16'h8010 + 16'(i)); end
        end
        $display("burst: %0d samples observed", n);
    endtask

    task automatic test_underrun();
        do_reset();
        repeat (4) @(negedge clk);
        total++; if (underrun_cnt !== 8'd0) begin bad++; $display("FAIL underrun_before_first: got %0d want 0", underrun_cnt); end
        s_valid = 1'b1;
        s_data  = 16'h000A;
        @(negedge clk);
        s_data  = 16'h000B;
        @(negedge clk);
        s_valid = 1'b0;
        total++; if (Xn !== 16'h000A || x_valid !== 1'b1) begin bad++; $display("FAIL underrun_s0: got xn=%h xv=%b want 000a/1", Xn, x_valid); end
        repeat (2) @(negedge clk);
        total++; if (Xn !== 16'h000B || underrun_cnt !== 8'd0) begin bad++; $display("FAIL underrun_s1: got xn=%h cnt=%0d want 000b/0", Xn, underrun_cnt); end
        repeat (2) @(negedge clk);
        total++; if (Xn !== 16'h0000 || x_valid !== 1'b0 || underrun_cnt !== 8'd1) begin
            bad++; $display("FAIL underrun_bubble1: got xn=%h xv=%b cnt=%0d want 0000/0/1", Xn, x_valid, underrun_cnt);
        end
        repeat (2) @(negedge clk);
        total++; if (underrun_cnt !== 8'd2) begin bad++; $display("FAIL underrun_bubble2: got %0d want 2", underrun_cnt); end
        repeat (600) @(negedge clk);
        total++; if (underrun_cnt !== 8'd255) begin bad++; $display("FAIL underrun_saturate: got %0d want 255", underrun_cnt); end
        $display("underrun: count after 300+ bubbles = %0d", underrun_cnt);
    endtask

    task automatic test_coef();
        goto_phase(1'b0);
        coef_load = 1'b1;
        a_in      = 16'd3;
        b_in      = 16'd5;
        s_valid   = 1'b1;
        s_data    = 16'h0077;
        @(negedge clk);
        coef_load = 1'b0;
        s_valid   = 1'b0;
        total++; if (a !== 16'd2 || b !== 16'd3) begin bad++; $display("FAIL coef_hold1: got a=%0d b=%0d want 2/3", a, b); end
        @(negedge clk);
        total++; if (a !== 16'd2) begin bad++; $display("FAIL coef_hold2: got a=%0d want 2", a); end
        @(negedge clk);
        total++; if (a !== 16'd3 || b !== 16'd5) begin bad++; $display("FAIL coef_apply: got a=%0d b=%0d want 3/5", a, b); end
        total++; if (Xn !== 16'h0077 || x_valid !== 1'b1) begin bad++; $display("FAIL coef_same_edge_xn: got xn=%h xv=%b want 0077/1", Xn, x_valid); end
        $display("coef: first load applied a=%0d b=%0d", a, b);
        goto_phase(1'b0);
        coef_load = 1'b1;
        a_in      = 16'd7;
        b_in      = 16'd9;
        @(negedge clk);
        total++; if (a !== 16'd3) begin bad++; $display("FAIL coef_override_hold1: got a=%0d want 3", a); end
        a_in = 16'd11;
        b_in = 16'd13;
        @(negedge clk);
        coef_load = 1'b0;
        total++; if (a !== 16'd3) begin bad++; $display("FAIL coef_override_hold2: got a=%0d want 3", a); end
        @(negedge clk);
        total++; if (a !== 16'd11 || b !== 16'd13) begin bad++; $display("FAIL coef_override: got a=%0d b=%0d want 11/13", a, b); end
        $display("coef: override applied a=%0d b=%0d", a, b);
    endtask

    task automatic test_reset_mid_burst();
        int n;
        goto_phase(1'b1);
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = 16'h0021 + 16'(i);
            @(negedge clk);
        end
        s_valid = 1'b0;
        total++; if (Xn !== 16'h0022 || x_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre: got xn=%h xv=%b want 0022/1", Xn, x_valid); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (Xn !== 16'h0000 || x_valid !== 1'b0) begin bad++; $display("FAIL midrst_async_xn: got xn=%h xv=%b want 0000/0", Xn, x_valid); end
        total++; if (switch !== 1'b1 || s_ready !== 1'b0) begin bad++; $display("FAIL midrst_async_ctl: got sw=%b rdy=%b want 1/0", switch, s_ready); end
        total++; if (a !== 16'd2 || b !== 16'd3 || underrun_cnt !== 8'd0) begin
            bad++; $display("FAIL midrst_async_coef: got a=%0d b=%0d cnt=%0d want 2/3/0", a, b, underrun_cnt);
        end
        @(negedge clk);
        rst     = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'h0031;
        @(negedge clk);
        s_valid = 1'b0;
        n = 0;
        while (x_valid !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        total++; if (x_valid !== 1'b1 || Xn !== 16'h0031) begin bad++; $display("FAIL midrst_first_after: got xn=%h xv=%b want 0031/1", Xn, x_valid); end
        $display("reset_mid_burst: first sample after reset = %h", Xn);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        s_valid   = 1'b0;
        s_data    = '0;
        a_in      = '0;
        b_in      = '0;
        coef_load = 1'b0;
        test_reset();
        test_stream();
        test_burst();
        test_underrun();
        test_coef();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
